// File: rtl/alu_wb_queue.sv
// alu_wb_queue: ALU writeback FIFO with valid/ready release and overflow statistics.
// Optional same-cycle empty-queue bypass enabled by defining ALU_WB_BYPASS_EN.
module alu_wb_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_result,
   input  logic                     in_zero,
   input  logic                     in_cout,
   input  logic                     in_overflow,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_result,
   output logic                     out_zero,
   output logic                     out_cout,
   output logic                     out_overflow,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_wen,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     sticky_ovf,
   output logic [CNT_W-1:0]         ovf_cnt,
   input  logic                     clr_stat
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 32 + 3 + TAG_W;

   logic [EW-1:0]    r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr, r_rd_ptr;
   logic             r_sticky;
   logic [CNT_W-1:0] r_ovf_cnt;
   logic             w_empty, w_full, w_byp, w_push, w_pop, w_wr, w_rd, w_ovf_ev;
   logic [EW-1:0]    w_in, w_head;

   assign w_in    = {in_result, in_zero, in_cout, in_overflow, in_tag};
   assign w_empty = r_wr_ptr == r_rd_ptr;
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) & (r_wr_ptr[AW] != r_rd_ptr[AW]);
`ifdef ALU_WB_BYPASS_EN
   assign w_byp = w_empty & in_valid;
`else
   assign w_byp = 1'b0;
`endif
   assign in_ready  = ~w_full;
   assign out_valid = ~w_empty | w_byp;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   // a bypassed entry consumed in the same cycle never touches the array
   assign w_wr      = w_push & ~(w_byp & out_ready);
   assign w_rd      = w_pop & ~w_empty;
   assign w_head    = w_byp ? w_in : (w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]]);
   assign {out_result, out_zero, out_cout, out_overflow, out_tag} = w_head;
   assign out_wen    = out_valid & (out_tag != '0);
   assign count      = r_wr_ptr - r_rd_ptr;
   assign w_ovf_ev   = w_push & in_overflow;
   assign sticky_ovf = r_sticky;
   assign ovf_cnt    = r_ovf_cnt;

   always_ff @(posedge clk)
      if (rst_n && w_wr) r_mem[r_wr_ptr[AW-1:0]] <= w_in;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // an overflow push beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sticky  <= 1'b0;
         r_ovf_cnt <= '0;
      end else if (w_ovf_ev) begin
         r_sticky  <= 1'b1;
         r_ovf_cnt <= clr_stat ? CNT_W'(1) : (&r_ovf_cnt ? r_ovf_cnt : r_ovf_cnt + CNT_W'(1));
      end else if (clr_stat) begin
         r_sticky  <= 1'b0;
         r_ovf_cnt <= '0;
      end
   end
endmodule

// File: doc/alu_wb_queue.md
Name: alu_wb_queue

Overview:
- Writeback buffer directly downstream of the 32-bit ALU.
- Captures each ALU result with its zero/cout/overflow flags and a destination tag into a small FIFO.
- Releases entries to the register-file write port under a valid/ready handshake.
- Keeps overflow statistics for the exception/debug path.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
TAG_W, 5, destination-register tag width
CNT_W, 16, width of saturating overflow event counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  ALU stage presents a result
in_ready  output  1  queue can accept; equals ~full
in_result  input  32  ALU result
in_zero  input  1  ALU zero flag
in_cout  input  1  ALU carry-out flag
in_overflow  input  1  ALU overflow flag
in_tag  input  TAG_W  destination register index
out_valid  output  1  head entry available
out_ready  input  1  writeback consumer accepts head
out_result  output  32  head result
out_zero  output  1  head zero flag
out_cout  output  1  head carry flag
out_overflow  output  1  head overflow flag
out_tag  output  TAG_W  head destination tag
out_wen  output  1  out_valid & (out_tag != 0); register $0 is never written
count  output  log2(DEPTH)+1  current occupancy
sticky_ovf  output  1  set by any accepted entry with overflow=1
ovf_cnt  output  CNT_W  saturating count of accepted overflow entries
clr_stat  input  1  synchronous clear of sticky_ovf and ovf_cnt

Behaviour:
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Pointers are log2(DEPTH)+1 bits, with the MSB as wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- Wrap-around: pointers increment modulo 2*DEPTH. Entry index uses the low bits.
- Latency: an entry pushed in cycle N is visible at the outputs (out_valid=1) in cycle N+1.
- Occupancy:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle (non-empty): count unchanged; both pointers advance.
- Full: in_ready=0, so a push is impossible. A pop while full frees a slot, and in_ready rises the next cycle; there is no same-cycle refill.
- Empty:
  - out_valid=0.
  - out_result/out_zero/out_cout/out_overflow/out_tag are forced to 0.
  - out_wen=0.
  - A pop is impossible.
- Head data comes from a combinational read of mem[rd_ptr]. Output data is stable while out_valid=1 and out_ready=0.
- Stats are evaluated on push, not on pop:
  - An accepted entry with in_overflow=1 sets sticky_ovf.
  - The same event increments ovf_cnt, saturating at 2^CNT_W-1.
  - clr_stat in the same cycle as an overflow push gives sticky_ovf=1 and ovf_cnt=1 (event wins over clear).
- Reset (rst_n=0 at a clock edge):
  - Pointers, count, sticky_ovf and ovf_cnt go to 0, so in_ready=1 and out_valid=0 the next cycle.
  - The memory array is not reset.
  - Reset mid-operation discards all queued entries. Any push in the reset cycle is ignored.
- No state machine beyond the pointer/occupancy logic.

Optional Feature:
Macro ALU_WB_BYPASS_EN.
- Defined: when the queue is empty and in_valid=1, out_valid=1 in the same cycle and the out_* ports show the in_* values.
  - If out_ready=1 as well, the entry is consumed without being written; pointers and count are unchanged.
  - Stats still update.
  - If out_ready=0, a normal push occurs.
- Not defined: strict one-cycle latency. out_valid depends only on registered state.

Test Plan:
- Single pass: push {result=0x0000_0005, zero=0, cout=1, ovf=0, tag=3}, out_ready=1 → cycle+1: out_valid=1, out_result=5, out_cout=1, out_wen=1. Next cycle count=0.
- Fill/full: DEPTH=4, push 0x10..0x13 with out_ready=0 → count=4, in_ready=0. A 5th push is ignored. Pop all → order 0x10, 0x11, 0x12, 0x13, then out_valid=0 and outputs 0.
- Wrap and simultaneous: continuous push and pop over 20 beats (results 0..19) at count=2 → count holds 2 and the output sequence is in order. This crosses the pointer wrap at least twice.
- Tag zero: push tag=0, result=0x0 → out_valid=1, out_zero=1, out_wen=0.
- Stats: push 3 entries with overflow=1, then clr_stat with a 4th overflow push in the same cycle → ovf_cnt 3 then 1, sticky_ovf stays 1. Preload at 0xFFFF plus one overflow push → stays 0xFFFF.
- Reset mid-op: 3 entries queued, rst_n=0 for one edge → next cycle count=0, out_valid=0, in_ready=1, sticky_ovf=0. With ALU_WB_BYPASS_EN defined: empty queue, in_valid=1, out_ready=1, result 0xDEAD_BEEF → out_result=0xDEAD_BEEF in the same cycle, count stays 0.
